// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: scheduler states,
// keypad ASCII codes and default serializer timing.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_SENDING,
    S_GAP
  } sched_state_t;

  localparam logic [7:0] KEY_0    = 8'h30;
  localparam logic [7:0] KEY_1    = 8'h31;
  localparam logic [7:0] KEY_2    = 8'h32;
  localparam logic [7:0] KEY_3    = 8'h33;
  localparam logic [7:0] KEY_4    = 8'h34;
  localparam logic [7:0] KEY_5    = 8'h35;
  localparam logic [7:0] KEY_6    = 8'h36;
  localparam logic [7:0] KEY_7    = 8'h37;
  localparam logic [7:0] KEY_8    = 8'h38;
  localparam logic [7:0] KEY_9    = 8'h39;
  localparam logic [7:0] KEY_STAR = 8'h2A;
  localparam logic [7:0] KEY_HASH = 8'h23;

  localparam int CLK_HZ_DEFAULT = 50_000_000;
  localparam int BAUD_DEFAULT   = 115_200;
  localparam int FRAME_BITS     = 10;
  localparam int CLKS_PER_BIT   = CLK_HZ_DEFAULT / BAUD_DEFAULT;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Producer handshake plus the uart_tx start/busy handshake, bundled as one bus.
// master = scheduler side, slave = producers and serializer.
interface uart_tx_sched_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         data_tx;
  logic               transmit;
  logic               tx_busy;

  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ready, data_tx, transmit
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ready, data_tx, transmit
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester above ptr (wrapping) wins.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  input  logic                     en,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id
);
  localparam int IW = $clog2(N_REQ);
  localparam int SW = IW + 1;

  // cand[k] is the requester index at search position k, i.e. (ptr+1+k) mod N_REQ
  logic [IW-1:0] cand [N_REQ];
  logic [SW-1:0] sum  [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign sum[gi]  = {1'b0, ptr} + SW'(gi + 1);
      assign cand[gi] = (sum[gi] >= SW'(N_REQ)) ? IW'(sum[gi] - SW'(N_REQ))
                                                 : sum[gi][IW-1:0];
    end
  endgenerate

  always_comb begin
    logic found;
    found  = 1'b0;
    gnt    = '0;
    gnt_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && en && req[cand[k]]) begin
        found          = 1'b1;
        gnt[cand[k]]   = 1'b1;
        gnt_id         = cand[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx between N_REQ byte producers: round-robin accept, start pulse,
// frame wait, inter-character gap and start-timeout recovery.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_tx_sched_if.master          bus,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     active,
  output logic                     err_timeout
);
  localparam int IW      = $clog2(N_REQ);
  localparam int CNT_MAX = max_int(GAP_CYCLES, START_TIMEOUT);
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_SAT = cnt_t'(CNT_MAX);
  localparam cnt_t GAP_END = cnt_t'(GAP_CYCLES);
  localparam cnt_t TO_END  = cnt_t'(START_TIMEOUT);

  sched_state_t  state_reg, state_next;
  cnt_t          cnt_reg, cnt_next;
  logic [IW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [7:0]    data_tx_reg, data_tx_next;
  logic [IW-1:0] grant_id_reg, grant_id_next;
  logic          transmit_c;
  logic          err_timeout_c;
  logic          arb_en;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_id;
  logic [7:0]       req_byte [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
      assign req_byte[gi] = bus.req_data[8*gi +: 8];
    end
  endgenerate

  // Reset also gates the accept strobe so nothing is offered while rst is low
  assign arb_en = (state_reg == S_IDLE) && rst;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (bus.req_valid),
    .ptr    (rr_ptr_reg),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == CNT_SAT) ? c : c + cnt_t'(1);
  endfunction

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    rr_ptr_next   = rr_ptr_reg;
    data_tx_next  = data_tx_reg;
    grant_id_next = grant_id_reg;
    transmit_c    = 1'b0;
    err_timeout_c = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (|gnt) begin
          data_tx_next  = req_byte[gnt_id];
          grant_id_next = gnt_id;
          rr_ptr_next   = gnt_id;
          state_next    = S_START;
        end
      end
      S_START: begin
        transmit_c = 1'b1;
        cnt_next   = '0;
        state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_next = S_SENDING;
        end else if (cnt_reg == TO_END) begin
          // Serializer never started: drop the byte rather than retry
          err_timeout_c = 1'b1;
          cnt_next      = '0;
          state_next    = S_GAP;
        end else begin
          cnt_next = sat_inc(cnt_reg);
        end
      end
      S_SENDING: begin
        if (!bus.tx_busy) begin
          cnt_next   = '0;
          state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_reg >= GAP_END) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = sat_inc(cnt_reg);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      rr_ptr_reg   <= IW'(N_REQ - 1);
      data_tx_reg  <= 8'h00;
      grant_id_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rr_ptr_reg   <= rr_ptr_next;
      data_tx_reg  <= data_tx_next;
      grant_id_reg <= grant_id_next;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.data_tx   = data_tx_reg;
  assign bus.transmit  = transmit_c;
  assign grant_id      = grant_id_reg;
  assign active        = (state_reg != S_IDLE);
  assign err_timeout   = err_timeout_c;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: stimulus queues expected transmits/timeouts,
// monitors compare whenever the scheduler pulses transmit or err_timeout.
module tb_uart_tx_sched;
  localparam int FRAME = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_sched_if #(.N_REQ(2)) bus_a ();
  uart_tx_sched_if #(.N_REQ(2)) bus_b ();

  logic [0:0] gid_a, gid_b;
  logic       act_a, act_b, to_a, to_b;

  uart_tx_sched #(.N_REQ(2), .GAP_CYCLES(16), .START_TIMEOUT(8)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .grant_id(gid_a), .active(act_a), .err_timeout(to_a)
  );

  uart_tx_sched #(.N_REQ(2), .GAP_CYCLES(0), .START_TIMEOUT(8)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .grant_id(gid_b), .active(act_b), .err_timeout(to_b)
  );

  // tx_busy models: high for FRAME cycles starting one cycle after transmit
  bit model_en_a = 1'b1, model_en_b = 1'b1;
  int busy_cnt_a = 0, busy_cnt_b = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cnt_a <= 0;
      busy_cnt_b <= 0;
    end else begin
      if (model_en_a && bus_a.transmit) busy_cnt_a <= FRAME;
      else if (busy_cnt_a != 0)         busy_cnt_a <= busy_cnt_a - 1;
      if (model_en_b && bus_b.transmit) busy_cnt_b <= FRAME;
      else if (busy_cnt_b != 0)         busy_cnt_b <= busy_cnt_b - 1;
    end
  end
  assign bus_a.tx_busy = (busy_cnt_a != 0);
  assign bus_b.tx_busy = (busy_cnt_b != 0);

  typedef struct {
    int id;
    int data;
    int gap;   // expected clocks since previous transmit, 0 = unchecked
  } tx_exp_t;

  tx_exp_t q_tx_a[$];
  tx_exp_t q_tx_b[$];
  int      q_to_a[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic tx_exp_t mk(input int id, input int data, input int gap);
    tx_exp_t e;
    e.id = id; e.data = data; e.gap = gap;
    return e;
  endfunction

  int last_tx_a = 0, tx_seen_a = 0;
  always @(negedge clk) begin : mon_a
    tx_exp_t e;
    int      t;
    if (rst) begin
      if (bus_a.transmit) begin
        chk("tx_expected_a", int'(q_tx_a.size() != 0), 1);
        if (q_tx_a.size() != 0) begin
          e = q_tx_a.pop_front();
          chk("grant_id_a", int'(gid_a), e.id);
          chk("data_tx_a", int'(bus_a.data_tx), e.data);
          if (e.gap != 0) chk("tx_spacing_a", cyc - last_tx_a, e.gap);
          $display("A tx #%0d: id=%0d data=0x%02h cycle=%0d", tx_seen_a + 1,
                   gid_a, bus_a.data_tx, cyc);
        end
        last_tx_a = cyc;
        tx_seen_a++;
      end
      if (to_a) begin
        chk("timeout_expected_a", int'(q_to_a.size() != 0), 1);
        if (q_to_a.size() != 0) begin
          t = q_to_a.pop_front();
          chk("timeout_delay_a", cyc - last_tx_a, t);
          $display("A timeout: %0d clocks after transmit", cyc - last_tx_a);
        end
      end
    end
  end

  int   last_tx_b = 0, tx_seen_b = 0, fall_b = 0, acc_b = 0;
  logic busy_b_prev = 1'b0;
  always @(negedge clk) begin : mon_b
    tx_exp_t e;
    if (rst) begin
      if (!bus_b.tx_busy && busy_b_prev) fall_b = cyc;
      if (|(bus_b.req_ready & bus_b.req_valid)) acc_b = cyc;
      if (bus_b.transmit) begin
        chk("tx_expected_b", int'(q_tx_b.size() != 0), 1);
        if (q_tx_b.size() != 0) begin
          e = q_tx_b.pop_front();
          chk("grant_id_b", int'(gid_b), e.id);
          chk("data_tx_b", int'(bus_b.data_tx), e.data);
          if (e.gap != 0) chk("tx_spacing_b", cyc - last_tx_b, e.gap);
          $display("B tx #%0d: id=%0d data=0x%02h cycle=%0d", tx_seen_b + 1,
                   gid_b, bus_b.data_tx, cyc);
        end
        last_tx_b = cyc;
        tx_seen_b++;
      end
    end
    busy_b_prev = bus_b.tx_busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_a(input int target);
    for (int i = 0; i < 600 && tx_seen_a < target; i++) tick();
    chk("wait_tx_a", int'(tx_seen_a >= target), 1);
  endtask

  task automatic wait_tx_b(input int target);
    for (int i = 0; i < 600 && tx_seen_b < target; i++) tick();
    chk("wait_tx_b", int'(tx_seen_b >= target), 1);
  endtask

  task automatic wait_idle_a();
    for (int i = 0; i < 600 && act_a; i++) tick();
    chk("wait_idle_a", int'(act_a), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_ready;

    bus_a.req_valid = 2'b11;
    bus_a.req_data  = {8'h32, 8'h31};
    bus_b.req_valid = 2'b00;
    bus_b.req_data  = 16'h0000;

    // Reset held with both requesters valid
    repeat (3) tick();
    chk("rst_req_ready", int'(bus_a.req_ready), 0);
    chk("rst_transmit", int'(bus_a.transmit), 0);
    chk("rst_active", int'(act_a), 0);
    chk("rst_grant_id", int'(gid_a), 0);
    chk("rst_data_tx", int'(bus_a.data_tx), 0);
    chk("rst_err_timeout", int'(to_a), 0);

    // Continuous requests: grants alternate, spacing 2+1+100+16+1
    q_tx_a.push_back(mk(0, 8'h31, 0));
    q_tx_a.push_back(mk(1, 8'h32, 120));
    q_tx_a.push_back(mk(0, 8'h31, 120));
    q_tx_a.push_back(mk(1, 8'h32, 120));
    rst = 1'b1;
    #1;
    chk("first_ready_req0", int'(bus_a.req_ready), 1);
    tick();
    chk("transmit_next_cycle", int'(bus_a.transmit), 1);
    chk("active_after_accept", int'(act_a), 1);
    wait_tx_a(4);
    bus_a.req_valid = 2'b00;

    // Start timeout: serializer never goes busy, byte dropped, no retry
    wait_idle_a();
    model_en_a      = 1'b0;
    bus_a.req_valid = 2'b01;
    bus_a.req_data  = {8'h32, 8'h2A};
    q_tx_a.push_back(mk(0, 8'h2A, 0));
    q_to_a.push_back(9);
    wait_tx_a(5);
    bus_a.req_valid = 2'b00;
    wait_idle_a();
    chk("timeout_to_idle", cyc - last_tx_a, 27);
    repeat (20) tick();
    chk("no_retry_after_timeout", tx_seen_a, 5);

    // Requester 1 arrives mid-frame and is taken in the first IDLE cycle
    model_en_a      = 1'b1;
    bus_a.req_valid = 2'b01;
    bus_a.req_data  = {8'h42, 8'h41};
    q_tx_a.push_back(mk(0, 8'h41, 0));
    q_tx_a.push_back(mk(1, 8'h42, 120));
    wait_tx_a(6);
    bus_a.req_valid = 2'b00;
    repeat (10) tick();
    bus_a.req_valid = 2'b10;
    bad_ready = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!act_a) break;
      if (bus_a.req_ready != 2'b00) bad_ready++;
    end
    chk("ready_low_while_busy", bad_ready, 0);
    chk("ready_first_idle", int'(bus_a.req_ready), 2);
    wait_tx_a(7);
    bus_a.req_valid = 2'b00;

    // Reset pulsed mid-frame: async return to reset values, rr_ptr back to N_REQ-1
    wait_idle_a();
    bus_a.req_valid = 2'b01;
    bus_a.req_data  = {8'h56, 8'h55};
    q_tx_a.push_back(mk(0, 8'h55, 0));
    wait_tx_a(8);
    bus_a.req_valid = 2'b00;
    repeat (20) tick();
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_active", int'(act_a), 0);
    chk("midrst_transmit", int'(bus_a.transmit), 0);
    chk("midrst_data_tx", int'(bus_a.data_tx), 0);
    chk("midrst_grant_id", int'(gid_a), 0);
    chk("midrst_err_timeout", int'(to_a), 0);
    bus_a.req_valid = 2'b11;
    bus_a.req_data  = {8'h62, 8'h61};
    #1;
    chk("midrst_req_ready", int'(bus_a.req_ready), 0);
    q_tx_a.push_back(mk(0, 8'h61, 0));
    repeat (3) tick();
    rst = 1'b1;
    wait_tx_a(9);
    bus_a.req_valid = 2'b00;

    // Zero-gap build: next grant two clocks after tx_busy falls
    bus_b.req_valid = 2'b11;
    bus_b.req_data  = {8'h72, 8'h71};
    q_tx_b.push_back(mk(0, 8'h71, 0));
    q_tx_b.push_back(mk(1, 8'h72, 104));
    wait_tx_b(2);
    bus_b.req_valid = 2'b00;
    chk("gap0_grant_after_fall", acc_b - fall_b, 2);

    repeat (5) tick();
    chk("queue_a_drained", q_tx_a.size() + q_to_a.size(), 0);
    chk("queue_b_drained", q_tx_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler that shares one `uart_tx` serializer between `N_REQ` byte producers (keypad decoder, status/message generator). It runs a round-robin arbiter and owns the `data_tx`/`transmit` handshake into `uart_tx`. It waits for each frame to complete, enforces a minimum inter-character gap, and recovers if the serializer never starts. It sits between the producer logic and `uart_tx` in the top level.

## Interface
Parameters:
- `N_REQ`, 2, number of requesters (≥2)
- `GAP_CYCLES`, 16, idle clocks between end of frame and next grant (0 allowed)
- `START_TIMEOUT`, 8, clocks to wait for `tx_busy` after `transmit` before abort (≥1)

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  bit i: requester i holds a byte.
- `req_data`  in  8*N_REQ  byte i at `[8*i+7:8*i]`; stable while valid.
- `req_ready`  out  N_REQ  one-hot accept strobe; the transfer occurs when valid&ready.
- `data_tx`  out  8  byte to `uart_tx`; registered and held until the next accept.
- `transmit`  out  1  one-cycle start pulse to `uart_tx`.
- `tx_busy`  in  1  high while `uart_tx` shifts a frame (start through stop bit).
- `grant_id`  out  $clog2(N_REQ)  index of the last accepted requester.
- `active`  out  1  high in every state except IDLE.
- `err_timeout`  out  1  one-cycle pulse when a start is aborted.

## Operation
- States: IDLE, START, WAIT_BUSY, SENDING, GAP.
- IDLE
  - The winner is the first requester with `req_valid` high, searching from `(rr_ptr+1) mod N_REQ` upward.
  - `req_ready[winner]` is driven combinationally in the same cycle.
  - On the accept edge: `data_tx <= req_data[winner]`, `grant_id <= winner`, `rr_ptr <= winner`, next state START.
  - With no valid request, stay in IDLE with `req_ready` all zero.
- START: `transmit=1` for exactly this cycle; clear the counter; go to WAIT_BUSY.
- WAIT_BUSY
  - If `tx_busy` is high, go to SENDING.
  - Otherwise increment the counter. When the counter reaches `START_TIMEOUT`, pulse `err_timeout` and go to GAP; the byte is dropped, not retried.
- SENDING: hold until `tx_busy` is sampled low, then go to GAP with the counter cleared.
- GAP: count `GAP_CYCLES` clocks, then go to IDLE. With `GAP_CYCLES=0`, GAP lasts one cycle.
- `req_ready` is zero in every state except IDLE. Requests that arrive mid-frame wait; they are never lost while valid is held.
- Fairness:
  - A requester that was just served has lowest priority at the next grant.
  - With all N_REQ requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0.
- Counter width is $clog2(max(GAP_CYCLES,START_TIMEOUT)+1) and it saturates. It does not wrap.

## Timing
- Reset values (while `rst`=0): state IDLE, `rr_ptr`=N_REQ-1 (requester 0 wins first), `data_tx`=8'h00, `transmit`=0, `req_ready`=0 (gated by reset), `grant_id`=0, `active`=0, `err_timeout`=0.
- Accept in cycle n, `transmit` high in cycle n+1, `active` high from n+1.
- Minimum spacing from one accept to the next: 2 + busy-wait + frame + GAP_CYCLES + 1 clocks.
- `tx_busy` is expected one cycle after `transmit`. A `tx_busy` that is already high in START is ignored until WAIT_BUSY samples it.
- A `tx_busy` glitch low inside SENDING ends the frame. The scheduler does not filter it.
- Reset asserted mid-frame returns to IDLE immediately. `transmit` is never re-issued for the interrupted byte.
- Simultaneous valid on all requesters in the same cycle is resolved by `rr_ptr`, with exactly one `req_ready` high.

## Structure
- Package `uart_pkg`:
  - `sched_state_t` enum.
  - ASCII constants for keypad codes (`'0'`=8'h30 … `'#'`=8'h23), shared with the keypad decoder.
  - Default frame and baud constants.
- Sub-module `rr_arbiter`:
  - Parameterized by N_REQ.
  - Inputs: `req`, `ptr`, `en`. Outputs: one-hot `gnt` and encoded `gnt_id`.
  - Purely combinational.
- `uart_tx_sched` holds the FSM, counter, and registers.

## Test plan
- Reset with `req_valid=2'b11` and rst low: `req_ready=0`, `transmit=0`. On rst release, requester 0 is accepted first, `data_tx=8'h31`, and `transmit` pulses one cycle later.
- Both requesters held valid, with a `tx_busy` model of 1-cycle delay and 100-cycle frame: the grant sequence is 0,1,0,1. Consecutive `transmit` pulses are exactly 2+1+100+16+1 clocks apart.
- Single requester with byte 8'h2A, `tx_busy` tied low: `err_timeout` pulses 8 clocks after WAIT_BUSY entry, and the FSM reaches IDLE after GAP with no retry.
- `req_valid[1]` rises during SENDING: `req_ready` stays 0 until IDLE, then requester 1 is accepted in the first IDLE cycle.
- Reset pulsed low while in SENDING: all outputs return to reset values asynchronously, and `rr_ptr` resets so requester 0 wins next.
- `GAP_CYCLES=0` build: the next grant occurs 2 clocks after `tx_busy` falls.
